// File: rtl/layer_mac_pkg.sv
// Shared definitions for the layer_mac slice: FSM states, output index
// constants and a clog2 helper for sizing the beat counter.
package layer_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    DONE
  } state_t;

  // Activation index that represents a zero pre-activation sum
  localparam int SUM_OFFSET = 512;
  // Largest activation index
  localparam int SUM_MAX    = 1023;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: signed multiply of an unsigned activation by a signed
// weight, load/add accumulator, then shift, offset and saturate to the
// unsigned activation index.
// Optional feature macro: LAYER_MAC_BIAS_EN (accumulator preloaded with bias).
module mac_lane
  import layer_mac_pkg::*;
#(
  parameter int INPUT_SIZE  = 8,
  parameter int WEIGHT_SIZE = 8,
  parameter int ACC_SIZE    = 20,
  parameter int FRAC_SHIFT  = 6,
  parameter int SUM_SIZE    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_SIZE-1:0]  in_data,
  input  logic [WEIGHT_SIZE-1:0] weight,
`ifdef LAYER_MAC_BIAS_EN
  input  logic [ACC_SIZE-1:0]    bias,
`endif
  input  logic                   load,
  input  logic                   add,
  input  logic                   scale,
  output logic [SUM_SIZE-1:0]    sum
);

  localparam int PROD_W = INPUT_SIZE + WEIGHT_SIZE + 1;

  logic signed [PROD_W-1:0] prod;
  logic        [ACC_SIZE-1:0] prod_ext;
  logic        [ACC_SIZE-1:0] load_base;
  logic signed [ACC_SIZE:0]   acc_ext;
  logic signed [ACC_SIZE:0]   shifted;
  logic signed [ACC_SIZE:0]   scaled;
  logic        [ACC_SIZE-1:0] acc_d, acc_q;
  logic        [SUM_SIZE-1:0] sum_d, sum_q;

  // Product, sign extension and saturating scale of the current accumulator
  always_comb begin
    prod     = $signed({1'b0, in_data}) * $signed(weight);
    prod_ext = {{(ACC_SIZE - PROD_W){prod[PROD_W-1]}}, prod};
`ifdef LAYER_MAC_BIAS_EN
    load_base = bias;
`else
    load_base = '0;
`endif
    acc_ext = {acc_q[ACC_SIZE-1], acc_q};
    shifted = acc_ext >>> FRAC_SHIFT;
    scaled  = shifted + $signed((ACC_SIZE + 1)'(SUM_OFFSET));
    acc_d   = acc_q;
    if (load)     acc_d = load_base + prod_ext;
    else if (add) acc_d = acc_q + prod_ext;
    sum_d = sum_q;
    if (scale) begin
      if (scaled[ACC_SIZE])                    sum_d = '0;
      else if (|scaled[ACC_SIZE-1:SUM_SIZE])   sum_d = SUM_SIZE'(SUM_MAX);
      else                                     sum_d = scaled[SUM_SIZE-1:0];
    end
  end

  // Accumulator and registered output sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/layer_mac.sv
// Per-layer multiply-accumulate stage: streams INPUT_NUM beats into
// NEURON_NUM parallel lanes, then emits scaled/saturated sums with a
// valid/ready handoff.
// Optional feature macro: LAYER_MAC_BIAS_EN (adds in_bias port).
module layer_mac
  import layer_mac_pkg::*;
#(
  parameter int NEURON_NUM  = 6,
  parameter int INPUT_NUM   = 8,
  parameter int INPUT_SIZE  = 8,
  parameter int WEIGHT_SIZE = 8,
  parameter int ACC_SIZE    = 20,
  parameter int FRAC_SHIFT  = 6,
  parameter int SUM_SIZE    = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUT_SIZE-1:0]             in_data,
  input  logic [NEURON_NUM*WEIGHT_SIZE-1:0] in_weights,
`ifdef LAYER_MAC_BIAS_EN
  input  logic [NEURON_NUM*ACC_SIZE-1:0]    in_bias,
`endif
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [NEURON_NUM*SUM_SIZE-1:0]    sums,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int CNT_W = (clog2(INPUT_NUM) < 1) ? 1 : clog2(INPUT_NUM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INPUT_NUM - 1);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             fire, handoff;
  logic             lane_load, lane_add, lane_scale;

  assign fire    = in_valid && in_ready_q;
  assign handoff = out_valid_q && out_ready;

  // Next-state, beat counting and lane control
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lane_load  = 1'b0;
    lane_add   = 1'b0;
    lane_scale = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          lane_load = 1'b1;
          if (INPUT_NUM == 1) begin
            state_d = SCALE;
          end else begin
            state_d = ACCUM;
            count_d = CNT_W'(1);
          end
        end
      end
      ACCUM: begin
        if (fire) begin
          lane_add = 1'b1;
          if (count_q == LAST) begin
            state_d = SCALE;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      SCALE: begin
        lane_scale = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (handoff) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered so both sit low during and right
    // after reset; out_valid therefore rises one cycle after entering DONE.
    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    out_valid_d = (state_q == DONE) && !handoff;
  end

  // FSM, counter and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar i = 0; i < NEURON_NUM; i++) begin : g_lane
    mac_lane #(
      .INPUT_SIZE (INPUT_SIZE),
      .WEIGHT_SIZE(WEIGHT_SIZE),
      .ACC_SIZE   (ACC_SIZE),
      .FRAC_SHIFT (FRAC_SHIFT),
      .SUM_SIZE   (SUM_SIZE)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .in_data(in_data),
      .weight (in_weights[i*WEIGHT_SIZE +: WEIGHT_SIZE]),
`ifdef LAYER_MAC_BIAS_EN
      .bias   (in_bias[i*ACC_SIZE +: ACC_SIZE]),
`endif
      .load   (lane_load),
      .add    (lane_add),
      .scale  (lane_scale),
      .sum    (sums[i*SUM_SIZE +: SUM_SIZE])
    );
  end

endmodule

// File: tb/tb_layer_mac.sv
// Self-checking bench for layer_mac with a dot-product reference model.
// Optional feature macro: LAYER_MAC_BIAS_EN (enables the bias scenario).
module tb_layer_mac;

  localparam int NN = 6;
  localparam int NI = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      in_data;
  logic [NN*8-1:0] in_weights;
`ifdef LAYER_MAC_BIAS_EN
  logic [NN*20-1:0] in_bias;
`endif
  logic            in_valid;
  logic            in_ready;
  logic [NN*10-1:0] sums;
  logic            out_valid;
  logic            out_ready;

  int n_checks = 0;
  int n_errors = 0;

  int bd[NI];
  int bw[NI][NN];
  int bias_val = 0;
  logic [NN*10-1:0] exp_sums;

  always #5 clk = ~clk;

  layer_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_weights(in_weights),
`ifdef LAYER_MAC_BIAS_EN
    .in_bias   (in_bias),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sums      (sums),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference: plain dot product, floor-divide by 64, offset, clamp
  function automatic logic [NN*10-1:0] model_sums();
    logic [NN*10-1:0] r;
    int acc;
    int s;
    r = '0;
    for (int l = 0; l < NN; l++) begin
      acc = bias_val;
      for (int b = 0; b < NI; b++) acc += bd[b] * bw[b][l];
      s = (acc >>> 6) + 512;
      if (s < 0) s = 0;
      if (s > 1023) s = 1023;
      r[l*10 +: 10] = s[9:0];
    end
    return r;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic fill_uniform(input int d, input int w);
    for (int b = 0; b < NI; b++) begin
      bd[b] = d;
      for (int l = 0; l < NN; l++) bw[b][l] = w;
    end
  endtask

  // Sends all NI beats, optionally with 1..gap_max idle cycles before each
  task automatic send_batch(input int gap_max);
    int gap;
    int waited;
    logic [7:0] wv;
    for (int b = 0; b < NI; b++) begin
      if (gap_max > 0) begin
        gap = $urandom_range(gap_max, 1);
        repeat (gap) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bd[b][7:0];
      for (int l = 0; l < NN; l++) begin
        wv = bw[b][l][7:0];
        in_weights[l*8 +: 8] = wv;
      end
      waited = 0;
      while (!in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_accept: in_ready stayed 0 for beat %0d", b);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid   = 1'b0;
    in_data    = 8'($urandom);
    in_weights = {NN{8'($urandom)}};
    check_bit("out_valid_t0", out_valid, 1'b0);
  endtask

  // Verifies latency, hold behaviour for `hold` cycles, and the handoff
  task automatic check_result(input string name, input int hold);
    exp_sums = model_sums();
    @(negedge clk);
    check_bit({name, "_valid_t1"}, out_valid, 1'b0);
    n_checks++;
    if (sums !== exp_sums) begin
      n_errors++;
      $display("FAIL %s_sums_t1: got %h expected %h", name, sums, exp_sums);
    end
    @(negedge clk);
    check_bit({name, "_valid_t2"}, out_valid, 1'b1);
    check_bit({name, "_ready_done"}, in_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_bit({name, "_valid_hold"}, out_valid, 1'b1);
      check_bit({name, "_ready_hold"}, in_ready, 1'b0);
    end
    n_checks++;
    if (sums !== exp_sums) begin
      n_errors++;
      $display("FAIL %s_sums: got %h expected %h", name, sums, exp_sums);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit({name, "_valid_after"}, out_valid, 1'b0);
    check_bit({name, "_ready_after"}, in_ready, 1'b1);
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_weights = '0;
    out_ready  = 1'b0;
`ifdef LAYER_MAC_BIAS_EN
    in_bias    = '0;
`endif
    repeat (3) @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    n_checks++;
    if (sums !== '0) begin
      n_errors++;
      $display("FAIL rst_sums: got %h expected 0", sums);
    end
    rst = 1'b1;
    #1;
    check_bit("rel_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    check_bit("rel_in_ready_high", in_ready, 1'b1);
  endtask

  task automatic test_basic();
    fill_uniform(64, 1);
    send_batch(0);
    check_result("basic", 0);
    n_checks++;
    if (exp_sums !== {NN{10'd520}}) begin
      n_errors++;
      $display("FAIL basic_model: got %h expected all 520", exp_sums);
    end
  endtask

  task automatic test_mixed();
    for (int b = 0; b < NI; b++) begin
      bd[b] = 32;
      bw[b][0] = 2;
      bw[b][1] = -2;
      for (int l = 2; l < NN; l++) bw[b][l] = $urandom_range(255) - 128;
    end
    send_batch(0);
    check_result("mixed", 0);
    n_checks++;
    if (sums[9:0] !== 10'd520 || sums[19:10] !== 10'd504) begin
      n_errors++;
      $display("FAIL mixed_lanes: got %0d/%0d expected 520/504", sums[9:0], sums[19:10]);
    end
  endtask

  task automatic test_backpressure();
    fill_uniform(64, 1);
    send_batch(0);
    check_result("backpressure", 10);
    fill_uniform(32, 2);
    send_batch(0);
    check_result("after_bp", 0);
  endtask

  task automatic test_gaps();
    fill_uniform(64, 1);
    send_batch(5);
    check_result("gaps", 1);
  endtask

  task automatic test_midreset();
    fill_uniform(200, 100);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd200;
      in_weights = {NN{8'd100}};
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_bit("mid_rst_in_ready", in_ready, 1'b0);
    check_bit("mid_rst_out_valid", out_valid, 1'b0);
    n_checks++;
    if (sums !== '0) begin
      n_errors++;
      $display("FAIL mid_rst_sums: got %h expected 0", sums);
    end
    @(negedge clk);
    rst = 1'b1;
    fill_uniform(64, 1);
    send_batch(0);
    check_result("post_reset", 0);
  endtask

  task automatic test_saturation();
    fill_uniform(255, 127);
    send_batch(0);
    check_result("sat_high", 0);
    fill_uniform(255, -128);
    send_batch(0);
    check_result("sat_low", 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < NI; b++) begin
        bd[b] = $urandom_range(255);
        for (int l = 0; l < NN; l++) bw[b][l] = $urandom_range(255) - 128;
      end
      send_batch($urandom_range(2));
      check_result("random", $urandom_range(3));
    end
  endtask

`ifdef LAYER_MAC_BIAS_EN
  task automatic test_bias();
    bias_val = -512;
    for (int l = 0; l < NN; l++) in_bias[l*20 +: 20] = bias_val[19:0];
    fill_uniform(64, 1);
    send_batch(0);
    check_result("bias", 0);
    n_checks++;
    if (sums !== {NN{10'd512}}) begin
      n_errors++;
      $display("FAIL bias_sums: got %h expected all 512", sums);
    end
    bias_val = 0;
    in_bias  = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_backpressure();
    test_gaps();
    test_midreset();
    test_saturation();
    test_back_to_back();
`ifdef LAYER_MAC_BIAS_EN
    test_bias();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
